// File: rtl/connector_pkg.sv
// rtl/connector_pkg.sv - shared types and constants for the connector receive merge
package connector_pkg;

    localparam int NUM_CH     = 3;
    localparam int DATA_W_DEF = 8;

    typedef logic [1:0] chan_t;

    // Round-robin successor over the three live channel indices.
    function automatic chan_t next_chan(input chan_t c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

endpackage

// File: rtl/connector_chan_fifo.sv
// rtl/connector_chan_fifo.sv - per-channel write-capture FIFO with drop detection
module connector_chan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk0,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the pre-edge count, so a same-edge pop never rescues a write.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign drop      = push && full;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk0) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk0) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/connector_rx_merge.sv
// rtl/connector_rx_merge.sv - three-channel write capture merged into one tagged stream
module connector_rx_merge
    import connector_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk0,
    input  logic              resetn,
    input  logic              wen0,
    input  logic              wen1,
    input  logic              wen2,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output chan_t             out_chan,
    output logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] ovf,
    input  logic              ovf_clr
);

    logic [NUM_CH-1:0] wen;
    logic [DATA_W-1:0] wdata [NUM_CH];
    logic [DATA_W-1:0] head  [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] pop;

    chan_t last;
    chan_t c1, c2, c3;
    chan_t grant;
    logic  grant_vld;
    logic  load_en;

    assign wen      = {wen2, wen1, wen0};
    assign wdata[0] = data0;
    assign wdata[1] = data1;
    assign wdata[2] = data2;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
        connector_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk0      (clk0),
            .resetn    (resetn),
            .push      (wen[i]),
            .push_data (wdata[i]),
            .pop       (pop[i]),
            .head_data (head[i]),
            .empty     (empty[i]),
            .full      (full[i]),
            .drop      (drop[i])
        );
    end

    assign load_en = !out_valid || out_ready;
    assign c1      = next_chan(last);
    assign c2      = next_chan(c1);
    assign c3      = next_chan(c2);

    // Scan starts just after the last grant, so the last winner ranks lowest.
    always_comb begin
        grant     = c1;
        grant_vld = 1'b1;
        if (!empty[c1])      grant = c1;
        else if (!empty[c2]) grant = c2;
        else if (!empty[c3]) grant = c3;
        else                 grant_vld = 1'b0;
    end

    assign pop = (load_en && grant_vld) ? (3'b001 << grant) : 3'b000;

    always_ff @(posedge clk0) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= 2'd0;
            last      <= 2'd2;
            ovf       <= '0;
        end else begin
            if (load_en) begin
                if (grant_vld) begin
                    out_valid <= 1'b1;
                    out_data  <= head[grant];
                    out_chan  <= grant;
                    last      <= grant;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            // A drop on the clearing edge must survive the clear.
            ovf <= (ovf_clr ? '0 : ovf) | drop;
        end
    end

endmodule
